// File: rtl/dff_bist.sv
// dff_bist -- built-in self-test driver and response checker for a D flip-flop
// with active-low asynchronous set and reset.
//
// Every vector occupies one DRIVE -> WAIT -> CHECK slot. Vector 0 forces the
// flop into reset. Vectors 1..NUM_VECTORS come from an 8-bit Fibonacci LFSR
// (x^8+x^6+x^5+x^4+1, shifting left) that advances once per CHECK. Each
// response is compared against a golden model of the flop. Results are held
// in DONE until the next accepted start.
//
// Ports
//   clock      in   shared rising-edge clock (BIST and flop under test)
//   reset      in   asynchronous active-low reset
//   start      in   begin a run (sampled in IDLE, and in DONE once done is up)
//   dut_D      out  data to the flop
//   dut_set    out  active-low asynchronous set to the flop
//   dut_reset  out  active-low asynchronous reset to the flop
//   dut_Q      in   flop Q
//   dut_Qbar   in   flop Qbar
//   busy       out  run in progress
//   done       out  sticky run-complete flag
//   pass       out  1 iff err_count==0 (valid while done=1)
//   err_count  out  mismatching vectors, saturating at all-ones
//   vec_count  out  index of the vector in the current slot (0 = forced reset)
module dff_bist #(
  parameter int         NUM_VECTORS = 16,
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         ERR_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             dut_D,
  output logic             dut_set,
  output logic             dut_reset,
  input  logic             dut_Q,
  input  logic             dut_Qbar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       vec_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [7:0]       LAST_VEC = 8'(NUM_VECTORS);
  localparam logic [ERR_W-1:0] ERR_ONE  = 1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t     r_state;
  logic [7:0] r_lfsr;
  logic       w_exp_q;
  logic       w_mismatch;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == ERR_MAX) ? c : c + ERR_ONE;
  endfunction

  // Golden model works on the vector still held on the drive outputs, which
  // stay stable from DRIVE through CHECK. Reset dominates set.
  assign w_exp_q    = !dut_reset ? 1'b0 : (!dut_set ? 1'b1 : dut_D);
  assign w_mismatch = (dut_Q != w_exp_q) || (dut_Qbar != !w_exp_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_lfsr    <= SEED;
      dut_D     <= 1'b0;
      dut_set   <= 1'b1;
      dut_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            err_count <= '0;
            vec_count <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            r_lfsr    <= SEED;
            r_state   <= S_DRIVE;
          end
        end

        // --- slot stage 1: apply vector (flop async set/reset acts now)
        S_DRIVE: begin
          busy <= 1'b1;
          if (vec_count == 8'd0) begin
            dut_D     <= 1'b0;
            dut_set   <= 1'b1;
            dut_reset <= 1'b0;
          end else begin
            dut_D <= r_lfsr[0];
            case (r_lfsr[2:1])
              2'b01:   begin dut_set <= 1'b0; dut_reset <= 1'b1; end
              2'b10:   begin dut_set <= 1'b1; dut_reset <= 1'b0; end
              default: begin dut_set <= 1'b1; dut_reset <= 1'b1; end
            endcase
          end
          r_state <= S_WAIT;
        end

        // --- slot stage 2: flop captures D on this edge
        S_WAIT: begin
          r_state <= S_CHECK;
        end

        // --- slot stage 3: sample response, advance generator
        S_CHECK: begin
          if (w_mismatch) begin
            err_count <= sat_inc(err_count);
          end
          r_lfsr <= lfsr_next(r_lfsr);
          if (vec_count == LAST_VEC) begin
            r_state <= S_DONE;
          end else begin
            vec_count <= vec_count + 8'd1;
            r_state   <= S_DRIVE;
          end
        end

        // First DONE cycle publishes the result and parks the drive lines;
        // a start is only accepted once done is visible, so a held start
        // still produces a one-cycle done pulse before relaunching.
        S_DONE: begin
          if (!done) begin
            done      <= 1'b1;
            pass      <= (err_count == '0);
            busy      <= 1'b0;
            dut_D     <= 1'b0;
            dut_set   <= 1'b1;
            dut_reset <= 1'b1;
          end else if (start) begin
            err_count <= '0;
            vec_count <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            r_lfsr    <= SEED;
            r_state   <= S_DRIVE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bist.sv
// Testbench for dff_bist: a behavioural flop with selectable faults sits
// beside the BIST; a reference model derives the vector list, expected
// responses and error counts directly from the stated rules.
module tb_dff_bist;

  localparam int         NV = 16;
  localparam logic [7:0] SD = 8'hA5;
  localparam int         EW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          dut_D, dut_set, dut_reset;
  logic          dut_Q, dut_Qbar;
  logic          busy, done, pass;
  logic [EW-1:0] err_count;
  logic [7:0]    vec_count;

  // 0 = good flop, 1 = Q stuck at 0, 2 = Qbar tied to Q
  int mode = 0;
  logic r_q;

  int n_checks = 0;
  int n_errors = 0;
  int busy_total = 0;

  dff_bist #(.NUM_VECTORS(NV), .SEED(SD), .ERR_W(EW)) u_bist (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dut_D     (dut_D),
    .dut_set   (dut_set),
    .dut_reset (dut_reset),
    .dut_Q     (dut_Q),
    .dut_Qbar  (dut_Qbar),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .vec_count (vec_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge dut_reset or negedge dut_set) begin
    if (!dut_reset)    r_q <= 1'b0;
    else if (!dut_set) r_q <= 1'b1;
    else               r_q <= dut_D;
  end

  assign dut_Q    = (mode == 1) ? 1'b0 : r_q;
  assign dut_Qbar = (mode == 2) ? dut_Q : ~r_q;

  always @(negedge clock) if (busy === 1'b1) busy_total++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] lfsr_at(input int k);
    logic [7:0] l = SD;
    for (int j = 0; j < k; j++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  // returns {D, set_n, reset_n} for vector k
  function automatic logic [2:0] vec_at(input int k);
    logic [7:0] l;
    if (k == 0) return 3'b010;
    l = lfsr_at(k);
    case (l[2:1])
      2'b01:   return {l[0], 2'b01};
      2'b10:   return {l[0], 2'b10};
      default: return {l[0], 2'b11};
    endcase
  endfunction

  function automatic int exp_q(input logic [2:0] v);
    if (!v[0]) return 0;
    if (!v[1]) return 1;
    return int'(v[2]);
  endfunction

  function automatic int mism(input int k, input int m);
    if (m == 2) return 1;
    if (m == 1) return (exp_q(vec_at(k)) == 1) ? 1 : 0;
    return 0;
  endfunction

  function automatic int sat(input int e);
    return (e > (1 << EW) - 1) ? (1 << EW) - 1 : e;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_D"},    32'(dut_D),     32'd0);
    chk({tag, "_set"},  32'(dut_set),   32'd1);
    chk({tag, "_rst"},  32'(dut_reset), 32'd1);
    chk({tag, "_busy"}, 32'(busy),      32'd0);
    chk({tag, "_done"}, 32'(done),      32'd0);
    chk({tag, "_pass"}, 32'(pass),      32'd0);
    chk({tag, "_err"},  32'(err_count), 32'd0);
    chk({tag, "_vec"},  32'(vec_count), 32'd0);
  endtask

  // Entered #1 after the edge at which start was sampled; returns #1 after
  // the edge where done rises.
  task automatic run_body();
    int errs = 0;
    int base = busy_total;
    logic [2:0] v;
    for (int i = 0; i <= NV; i++) begin
      tick((i == 0) ? 1 : 3);
      v = vec_at(i);
      chk("drv_D",   32'(dut_D),     32'(v[2]));
      chk("drv_set", 32'(dut_set),   32'(v[1]));
      chk("drv_rst", 32'(dut_reset), 32'(v[0]));
      chk("vec_idx", 32'(vec_count), 32'(i));
      chk("busy_run", 32'(busy),     32'd1);
      chk("err_run", 32'(err_count), 32'(sat(errs)));
      if (i == 0) chk("v0_q", 32'(dut_Q), 32'd0);
      errs += mism(i, mode);
    end
    tick(2);
    chk("done_early", 32'(done), 32'd0);
    chk("busy_last",  32'(busy), 32'd1);
    tick(1);
    chk("done",      32'(done),      32'd1);
    chk("busy_end",  32'(busy),      32'd0);
    chk("pass",      32'(pass),      32'((errs == 0) ? 1 : 0));
    chk("err_final", 32'(err_count), 32'(sat(errs)));
    chk("vec_final", 32'(vec_count), 32'(NV));
    chk("idle_D",    32'(dut_D),     32'd0);
    chk("idle_set",  32'(dut_set),   32'd1);
    chk("idle_rst",  32'(dut_reset), 32'd1);
    chk("busy_cyc",  32'(busy_total - base), 32'(3 * (NV + 1)));
  endtask

  task automatic go();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    run_body();
    tick($urandom_range(1, 4));
    chk("hold_done", 32'(done), 32'd1);
  endtask

  // Abort a run with reset during vector k, 'ph' cycles into its slot.
  task automatic abort_at(input int k, input int ph);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1 + 3 * k + ph);
    #2 reset = 1'b0;
    #1 chk_reset_vals("abort");
    tick(1);
    reset = 1'b1;
    tick($urandom_range(1, 3));
  endtask

  initial begin
    #2 reset = 1'b0;
    tick(3);
    chk_reset_vals("por");
    reset = 1'b1;
    tick($urandom_range(1, 5));
    chk("idle_busy", 32'(busy), 32'd0);

    mode = 0; go();
    mode = 1; go();
    mode = 2; go();

    // reset at the WAIT of vector 5, then a clean rerun
    mode = 0;
    abort_at(5, 1);
    go();

    // random abort points and random fault modes
    for (int r = 0; r < 3; r++) begin
      abort_at($urandom_range(0, NV), $urandom_range(0, 2));
      mode = $urandom_range(0, 2);
      go();
    end

    // start held high across a whole run
    mode = 0;
    start = 1'b1;
    tick(1);
    run_body();
    tick(1);
    chk("relaunch_done", 32'(done), 32'd0);
    start = 1'b0;
    run_body();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
